ctrl_mem_state: RTL and testbench

- Command-driven sequencer for the state-bank memory: current-state banks (one write enable for all PEs) and previous-state banks (per-PE write enables, one extra address MSB selecting a region).
- Executes WRITE commands: streams PE writeback beats into the current-state banks of one layer.
- Executes SCAN commands: sweeps current- and previous-state banks of one layer in lockstep and streams the pairs to the delta encoder with valid/ready backpressure.
- Collects masked previous-state updates returned by the delta encoder and writes them to the previous-state banks.

---
 rtl/ctrl_mem_state.sv | 165 ++++++++++++++++
 tb/tb_ctrl_mem_state.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_state.sv
// Command sequencer for the state-bank memory: streams writeback words into the current-state
// banks, scans current/previous banks in lockstep to the delta encoder, and applies updates.
module ctrl_mem_state #(
  parameter int unsigned NUM_PE             = 16,
  parameter int unsigned ACT_BW             = 16,
  parameter int unsigned NUM_LAYER_BW       = 2,
  parameter int unsigned MEM_STATE_DEPTH_BW = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [NUM_LAYER_BW-1:0]         cmd_layer,
  input  logic                            cmd_region,
  input  logic [MEM_STATE_DEPTH_BW:0]     cmd_len,
  input  logic                            wb_valid,
  output logic                            wb_ready,
  input  logic [NUM_PE*ACT_BW-1:0]        wb_data,
  output logic                            scan_valid,
  input  logic                            scan_ready,
  output logic [NUM_PE*ACT_BW-1:0]        scan_curr,
  output logic [NUM_PE*ACT_BW-1:0]        scan_prev,
  input  logic                            upd_valid,
  input  logic [NUM_PE-1:0]               upd_mask,
  input  logic [NUM_PE*ACT_BW-1:0]        upd_data,
  output logic                            done,
  output logic                            curr_wr_en,
  output logic                            curr_rd_en,
  output logic                            prev_rd_en,
  output logic [NUM_PE-1:0]               prev_wr_en,
  output logic [NUM_LAYER_BW-1:0]         curr_l_wr_addr,
  output logic [NUM_LAYER_BW-1:0]         curr_l_rd_addr,
  output logic [NUM_LAYER_BW-1:0]         prev_l_wr_addr,
  output logic [NUM_LAYER_BW-1:0]         prev_l_rd_addr,
  output logic [MEM_STATE_DEPTH_BW-1:0]   curr_wr_addr,
  output logic [MEM_STATE_DEPTH_BW-1:0]   curr_rd_addr,
  output logic [MEM_STATE_DEPTH_BW:0]     prev_wr_addr,
  output logic [MEM_STATE_DEPTH_BW:0]     prev_rd_addr,
  output logic [NUM_PE*ACT_BW-1:0]        curr_din,
  output logic [NUM_PE*ACT_BW-1:0]        prev_din,
  input  logic [NUM_PE*ACT_BW-1:0]        curr_dout,
  input  logic [NUM_PE*ACT_BW-1:0]        prev_dout
);

  localparam int unsigned W  = NUM_PE * ACT_BW;
  localparam int unsigned CW = MEM_STATE_DEPTH_BW + 1;
  localparam logic [CW-1:0] One = CW'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StScan, StDone} state_e;

  state_e                  r_state, w_state_next;
  logic [NUM_LAYER_BW-1:0] r_layer;
  logic                    r_region;
  logic [CW-1:0]           r_len;
  logic [CW-1:0]           r_wr_cnt, r_rd_cnt, r_out_cnt, r_upd_cnt;
  logic                    r_inflight;
  logic [1:0]              r_occ;
  logic                    r_wptr, r_rptr;
  logic [W-1:0]            r_fifo_curr [2];
  logic [W-1:0]            r_fifo_prev [2];

  logic       w_accept, w_wb_fire, w_pop, w_rd_issue, w_upd_fire;
  logic [1:0] w_occ_after_pop;

  assign w_accept   = (r_state == StIdle) && cmd_valid;
  assign w_wb_fire  = (r_state == StWrite) && wb_valid;
  assign w_pop      = scan_valid && scan_ready;
  assign w_upd_fire = (r_state == StScan) && upd_valid && (r_upd_cnt < r_len);

  // Credit check counts this cycle's pop so a steady stream runs at one beat per cycle.
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign w_rd_issue      = (r_state == StScan) && (r_rd_cnt < r_len) &&
                           ((w_occ_after_pop + {1'b0, r_inflight}) < 2'd2);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_len == '0) w_state_next = StDone;
          else               w_state_next = cmd_op ? StScan : StWrite;
        end
      end
      StWrite: begin
        if (w_wb_fire && ((r_wr_cnt + One) == r_len)) w_state_next = StDone;
      end
      StScan: begin
        if ((r_out_cnt == r_len) && (r_upd_cnt == r_len)) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign cmd_ready  = (r_state == StIdle);
  assign wb_ready   = (r_state == StWrite);
  assign done       = (r_state == StDone);
  assign scan_valid = (r_occ != 2'd0);
  assign scan_curr  = r_fifo_curr[r_rptr];
  assign scan_prev  = r_fifo_prev[r_rptr];

  assign curr_wr_en     = w_wb_fire;
  assign curr_wr_addr   = r_wr_cnt[MEM_STATE_DEPTH_BW-1:0];
  assign curr_l_wr_addr = r_layer;
  assign curr_din       = wb_data;

  assign curr_rd_en     = w_rd_issue;
  assign prev_rd_en     = w_rd_issue;
  assign curr_rd_addr   = r_rd_cnt[MEM_STATE_DEPTH_BW-1:0];
  assign prev_rd_addr   = {r_region, r_rd_cnt[MEM_STATE_DEPTH_BW-1:0]};
  assign curr_l_rd_addr = r_layer;
  assign prev_l_rd_addr = r_layer;

  assign prev_wr_en     = w_upd_fire ? upd_mask : '0;
  assign prev_wr_addr   = {r_region, r_upd_cnt[MEM_STATE_DEPTH_BW-1:0]};
  assign prev_l_wr_addr = r_layer;
  assign prev_din       = upd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_layer    <= '0;
      r_region   <= 1'b0;
      r_len      <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_out_cnt  <= '0;
      r_upd_cnt  <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_rd_issue;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
      if (w_accept) begin
        r_layer   <= cmd_layer;
        r_region  <= cmd_region;
        r_len     <= cmd_len;
        r_wr_cnt  <= '0;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
        r_upd_cnt <= '0;
      end else begin
        if (w_wb_fire)  r_wr_cnt  <= r_wr_cnt + One;
        if (w_rd_issue) r_rd_cnt  <= r_rd_cnt + One;
        if (w_pop)      r_out_cnt <= r_out_cnt + One;
        if (w_upd_fire) r_upd_cnt <= r_upd_cnt + One;
      end
    end
  end

  // Memory returns read data exactly one cycle after the read is issued.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_curr[r_wptr] <= curr_dout;
      r_fifo_prev[r_wptr] <= prev_dout;
    end
  end

endmodule

// File: tb/tb_ctrl_mem_state.sv
// Bench for ctrl_mem_state: behavioural state-bank memory, scoreboard queues for writes, scan
// beats and updates, a command table plus hand-written reset and busy-command sequences.
module tb_ctrl_mem_state;
  localparam int NPE = 16;
  localparam int ABW = 16;
  localparam int W   = NPE * ABW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_valid, cmd_ready, cmd_op, cmd_region;
  logic [1:0] cmd_layer;
  logic [5:0] cmd_len;
  logic wb_valid, wb_ready, scan_valid, scan_ready, upd_valid, done;
  logic [W-1:0] wb_data, scan_curr, scan_prev, upd_data;
  logic [NPE-1:0] upd_mask, prev_wr_en;
  logic curr_wr_en, curr_rd_en, prev_rd_en;
  logic [1:0] curr_l_wr_addr, curr_l_rd_addr, prev_l_wr_addr, prev_l_rd_addr;
  logic [4:0] curr_wr_addr, curr_rd_addr;
  logic [5:0] prev_wr_addr, prev_rd_addr;
  logic [W-1:0] curr_din, prev_din, curr_dout, prev_dout;

  ctrl_mem_state dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_layer(cmd_layer), .cmd_region(cmd_region), .cmd_len(cmd_len),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_curr(scan_curr),
    .scan_prev(scan_prev), .upd_valid(upd_valid), .upd_mask(upd_mask), .upd_data(upd_data),
    .done(done), .curr_wr_en(curr_wr_en), .curr_rd_en(curr_rd_en), .prev_rd_en(prev_rd_en),
    .prev_wr_en(prev_wr_en), .curr_l_wr_addr(curr_l_wr_addr), .curr_l_rd_addr(curr_l_rd_addr),
    .prev_l_wr_addr(prev_l_wr_addr), .prev_l_rd_addr(prev_l_rd_addr),
    .curr_wr_addr(curr_wr_addr), .curr_rd_addr(curr_rd_addr), .prev_wr_addr(prev_wr_addr),
    .prev_rd_addr(prev_rd_addr), .curr_din(curr_din), .prev_din(prev_din),
    .curr_dout(curr_dout), .prev_dout(prev_dout)
  );

  function automatic logic [W-1:0] pat(input int b, input int l, input int a);
    logic [W-1:0] w;
    for (int i = 0; i < NPE; i++) w[i*ABW +: ABW] = 16'(b * 'h4000 + l * 'h1000 + a * 'h10 + i);
    return w;
  endfunction

  function automatic logic [W-1:0] wbw(input int l, input int a);
    logic [W-1:0] w;
    for (int i = 0; i < NPE; i++) w[i*ABW +: ABW] = 16'('hA0 + a + l * 'h100 + i * 'h1000);
    return w;
  endfunction

  // Behavioural memory: one-cycle read latency, read-first on collisions.
  bit mem_init;
  logic [W-1:0] cmem [4][32];
  logic [W-1:0] pmem [4][64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int l = 0; l < 4; l++)
        for (int a = 0; a < 64; a++) begin
          pmem[l][a] <= pat(1, l, a);
          if (a < 32) cmem[l][a] <= pat(0, l, a);
        end
    end else begin
      if (curr_wr_en) cmem[curr_l_wr_addr][curr_wr_addr] <= curr_din;
      for (int i = 0; i < NPE; i++)
        if (prev_wr_en[i])
          pmem[prev_l_wr_addr][prev_wr_addr][i*ABW +: ABW] <= prev_din[i*ABW +: ABW];
    end
    if (curr_rd_en) curr_dout <= cmem[curr_l_rd_addr][curr_rd_addr];
    if (prev_rd_en) prev_dout <= pmem[prev_l_rd_addr][prev_rd_addr];
  end

  typedef struct {logic [1:0] l; logic [4:0] a; logic [W-1:0] d;} wr_t;
  typedef struct {logic [W-1:0] c; logic [W-1:0] p;} scn_t;
  typedef struct {logic [1:0] l; logic [5:0] a; logic [NPE-1:0] m; logic [W-1:0] d;} up_t;
  wr_t  wr_q[$];
  scn_t sc_q[$];
  up_t  up_q[$];

  logic [W-1:0] sc [4][32];
  logic [W-1:0] sp [4][64];

  int n_vec = 0, n_err = 0;
  int n_done = 0, n_beats = 0, n_iss = 0, n_wr = 0, max_out = 0;
  bit mon_en = 1'b0;
  logic [NPE-1:0] masks [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e; scn_t s; up_t u;
      if (done) n_done++;
      if (curr_wr_en) begin
        n_wr++;
        if (wr_q.size() == 0) chk("curr_wr_unexpected", int'(curr_wr_en), 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_layer", int'(curr_l_wr_addr), int'(e.l));
          chk("wr_addr", int'(curr_wr_addr), int'(e.a));
          chkw("wr_data", curr_din, e.d);
        end
      end
      if (scan_valid && scan_ready) begin
        n_beats++;
        if (sc_q.size() == 0) chk("scan_beat_unexpected", int'(scan_valid), 0);
        else begin
          s = sc_q.pop_front();
          chkw("scan_curr", scan_curr, s.c);
          chkw("scan_prev", scan_prev, s.p);
        end
      end
      if (curr_rd_en) n_iss++;
      if (n_iss - n_beats > max_out) max_out = n_iss - n_beats;
      if (upd_valid && up_q.size() != 0) begin
        u = up_q.pop_front();
        chk("upd_wr_en", int'(prev_wr_en), int'(u.m));
        chk("upd_addr", int'(prev_wr_addr), int'(u.a));
        chk("upd_layer", int'(prev_l_wr_addr), int'(u.l));
        if (u.m != '0) chkw("upd_data", prev_din, u.d);
      end else if (prev_wr_en != '0) begin
        chk("prev_wr_unexpected", int'(prev_wr_en), 0);
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!cmd_ready && n < 300);
    if (!cmd_ready) chk("cmd_accept_timeout", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input bit op, input int l, input bit r, input int len);
    cmd_valid = 1'b1; cmd_op = op; cmd_layer = 2'(l); cmd_region = r; cmd_len = 6'(len);
    wait_accept();
  endtask

  task automatic write_beats(input int l, input int len);
    logic [W-1:0] dat;
    for (int a = 0; a < len; a++) begin
      dat = wbw(l, a);
      wb_valid = 1'b1; wb_data = dat;
      wr_q.push_back('{l: 2'(l), a: 5'(a), d: dat});
      sc[l][a] = dat;
      @(negedge clk); #1; chk("wb_ready", int'(wb_ready), 1);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    @(negedge clk); #1; chk("done_after_last_beat", int'(done), 1);
    @(posedge clk); #1;
    @(negedge clk); #1; chk("write_done_one_cycle", int'(done), 0);
    @(posedge clk); #1;
    chk("wr_q_drained", wr_q.size(), 0);
  endtask

  task automatic push_scan(input int l, input bit r, input int len);
    for (int a = 0; a < len; a++) sc_q.push_back('{c: sc[l][a], p: sp[l][int'(r) * 32 + a]});
  endtask

  // Runs an accepted SCAN to completion; umode 0: mask-0 updates from the start,
  // umode 1: updates from masks[] only after every beat has been delivered.
  task automatic scan_body(input int l, input bit r, input int len, input int rmode,
                           input int umode, input int exp_beats, input int exp_lat);
    int cyc = 0, first = -1, fpop = -1, last = -1, nup = 0, b0 = n_beats, d0 = n_done;
    logic [NPE-1:0] m;
    logic [W-1:0] d;
    while (n_done == d0 && cyc < 600) begin
      scan_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      upd_valid = 1'b0;
      if (nup < len && (umode == 0 || n_beats - b0 == len)) begin
        m = (umode == 1) ? masks[nup] : '0;
        d = {8{$urandom()}};
        upd_valid = 1'b1; upd_mask = m; upd_data = d;
        up_q.push_back('{l: 2'(l), a: 6'(int'(r) * 32 + nup), m: m, d: d});
        for (int i = 0; i < NPE; i++)
          if (m[i]) sp[l][int'(r) * 32 + nup][i*ABW +: ABW] = d[i*ABW +: ABW];
        nup++;
      end
      @(negedge clk); #1;
      if (scan_valid && first < 0) first = cyc;
      if (scan_valid && scan_ready) begin
        if (fpop < 0) fpop = cyc;
        last = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    upd_valid = 1'b0; scan_ready = 1'b0;
    chk("scan_done_seen", n_done - d0, 1);
    chk("scan_beats", n_beats - b0, exp_beats);
    chk("updates_before_done", nup, len);
    chk("first_valid_latency", first, exp_lat);
    if (rmode == 0) chk("beats_back_to_back", last - fpop, len - 1);
    chk("outstanding_le2", int'(max_out <= 2), 1);
    chk("scan_q_drained", sc_q.size(), 0);
    @(negedge clk); #1; chk("scan_done_one_cycle", int'(done), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit op; int l; bit r; int len; int rmode; int umode; int exp_beats; int exp_lat;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int w0, d0, b0, k;
    tbl[0] = '{1'b0, 2, 1'b0, 4,  0, 0, 4,  0};
    tbl[1] = '{1'b1, 1, 1'b1, 32, 0, 0, 32, 2};
    tbl[2] = '{1'b1, 1, 1'b0, 8,  1, 0, 8,  2};
    tbl[3] = '{1'b1, 0, 1'b1, 8,  2, 0, 8,  2};
    tbl[4] = '{1'b1, 2, 1'b0, 4,  0, 0, 4,  2};
    tbl[5] = '{1'b1, 0, 1'b0, 4,  0, 1, 4,  2};
    tbl[6] = '{1'b0, 3, 1'b0, 0,  0, 0, 0,  0};
    tbl[7] = '{1'b0, 1, 1'b0, 32, 0, 0, 32, 0};
    tbl[8] = '{1'b1, 1, 1'b0, 32, 2, 0, 32, 2};
    masks[0] = 16'hFFFF; masks[1] = 16'h0001; masks[2] = 16'h0000; masks[3] = 16'h8000;

    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 64; a++) begin
        sp[l][a] = pat(1, l, a);
        if (a < 32) sc[l][a] = pat(0, l, a);
      end

    rst = 1'b1; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_layer = '0; cmd_region = 1'b0; cmd_len = '0;
    wb_valid = 1'b0; wb_data = '0; scan_ready = 1'b0;
    upd_valid = 1'b0; upd_mask = '0; upd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_scan_valid", int'(scan_valid), 0);
    chk("reset_wb_ready", int'(wb_ready), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_enables", int'({curr_wr_en, curr_rd_en, prev_rd_en, prev_wr_en}), 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0; mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].op == 1'b0) begin
        w0 = n_wr;
        do_cmd(1'b0, tbl[i].l, 1'b0, tbl[i].len);
        write_beats(tbl[i].l, tbl[i].len);
        chk("write_count", n_wr - w0, tbl[i].exp_beats);
      end else begin
        push_scan(tbl[i].l, tbl[i].r, tbl[i].len);
        max_out = 0;
        do_cmd(1'b1, tbl[i].l, tbl[i].r, tbl[i].len);
        scan_body(tbl[i].l, tbl[i].r, tbl[i].len, tbl[i].rmode, tbl[i].umode,
                  tbl[i].exp_beats, tbl[i].exp_lat);
        if (tbl[i].umode == 1)
          for (int a = 0; a < tbl[i].len; a++)
            chkw("prev_mem_after_update", pmem[tbl[i].l][int'(tbl[i].r) * 32 + a],
                 sp[tbl[i].l][int'(tbl[i].r) * 32 + a]);
      end
    end

    // A SCAN offered during a WRITE must wait for cmd_ready.
    do_cmd(1'b0, 3, 1'b0, 2);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_layer = 2'd3; cmd_region = 1'b0; cmd_len = 6'd2;
    @(negedge clk); #1; chk("busy_cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    write_beats(3, 2);
    cmd_valid = 1'b0;
    push_scan(3, 1'b0, 2);
    max_out = 0;
    scan_body(3, 1'b0, 2, 0, 0, 2, 2);

    // Reset in the middle of a SCAN after three beats.
    push_scan(1, 1'b0, 8);
    max_out = 0;
    d0 = n_done; b0 = n_beats;
    do_cmd(1'b1, 1, 1'b0, 8);
    scan_ready = 1'b1;
    k = 0;
    while (n_beats - b0 < 3 && k < 50) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      k++;
    end
    chk("beats_before_reset", n_beats - b0, 3);
    rst = 1'b1; scan_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sc_q.delete(); up_q.delete();
    n_iss = n_beats;
    @(negedge clk); #1;
    chk("abort_enables",
        int'({curr_wr_en, curr_rd_en, prev_rd_en, prev_wr_en, scan_valid, wb_ready}), 0);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    chk("abort_read_discarded", int'(scan_valid), 0);
    chk("abort_no_done", n_done - d0, 0);
    @(posedge clk); #1;
    w0 = n_wr;
    do_cmd(1'b0, 3, 1'b0, 4);
    write_beats(3, 4);
    chk("write_after_abort", n_wr - w0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
